sig_result_writer: RTL and testbench

//  Drain side of the sigmoid unit: accepts 8-bit activations over the dout/dout_valid/dout_ack handshake.

---
 rtl/ann_sig_pkg.sv | 28 ++
 rtl/sig_lane_packer.sv | 59 +++++
 rtl/sig_result_writer.sv | 185 ++++++++++++++++++
 tb/tb_sig_result_writer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ann_sig_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ann_sig_pkg
//  Description : Shared constants for the sigmoid drain path: destination
//                select codes, activation width, layer-RAM address width and
//                the result-writer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package ann_sig_pkg;

    // Activation width produced by the sigmoid unit
    localparam int DATA_WIDTH  = 8;

    // Word-address width of the neuron-value (layer) RAM
    localparam int SIG_RAM_ADR = 10;

    // Destination select codes: hidden layer vs. output layer
    localparam logic [2:0] IM_DSTSEL_SIG1 = 3'd1;
    localparam logic [2:0] IM_DSTSEL_SIG2 = 3'd2;

    // Result-writer state encoding
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_collect = 2'd1;
    localparam logic [1:0] c_st_write   = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

endpackage : ann_sig_pkg
`default_nettype wire

// File: rtl/sig_lane_packer.sv
`default_nettype none
// ============================================================================
//  Module      : sig_lane_packer
//  Description : Collects activations into PACK_N byte lanes of one memory
//                word. Tracks how many lanes hold data and derives the lane
//                byte-enables from that fill level. Unfilled lanes read 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sig_lane_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_N     = 4,
    parameter int FILL_W     = $clog2(PACK_N + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_capture,
    input  logic                         i_clear,
    input  logic [DATA_WIDTH-1:0]        i_din,
    output logic [DATA_WIDTH*PACK_N-1:0] o_data,
    output logic [PACK_N-1:0]            o_be,
    output logic                         o_full
);

    // Number of lanes filled so far; doubles as the next lane index
    logic [FILL_W-1:0] r_fill;

    // Fill level advances on each capture and returns to lane 0 on clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill <= '0;
        end else if (i_clear) begin
            r_fill <= '0;
        end else if (i_capture) begin
            r_fill <= r_fill + FILL_W'(1);
        end
    end

    for (genvar k = 0; k < PACK_N; k++) begin : g_lane
        logic [DATA_WIDTH-1:0] r_lane;

        // Each lane loads only when it is the current fill position
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_lane <= '0;
            end else if (i_clear) begin
                r_lane <= '0;
            end else if (i_capture && (r_fill == FILL_W'(k))) begin
                r_lane <= i_din;
            end
        end

        assign o_data[k*DATA_WIDTH +: DATA_WIDTH] = r_lane;
        assign o_be[k]                            = (r_fill > FILL_W'(k));
    end

    assign o_full = (r_fill == FILL_W'(PACK_N));

endmodule : sig_lane_packer
`default_nettype wire

// File: rtl/sig_result_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sig_result_writer
//  Description : Drain side of the sigmoid unit. Accepts activations over the
//                dout/dout_valid/dout_ack handshake, packs PACK_N of them per
//                word and writes the words to layer RAM from a programmed
//                base address. Output-layer activations are also copied to
//                the result port.
//  Options     : SIG_RESULT_WRITER_STALL_CNT_EN - adds stall_cnt output that
//                counts cycles the RAM holds off a pending write.
//  Revision    : 1.0 - initial release
// ============================================================================
module sig_result_writer #(
    parameter int DATA_WIDTH = ann_sig_pkg::DATA_WIDTH,
    parameter int PACK_N     = 4,
    parameter int ADR_W      = ann_sig_pkg::SIG_RAM_ADR,
    parameter int CNT_W      = 12
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         start,
    input  logic [ADR_W-1:0]             base_adr,
    input  logic [CNT_W-1:0]             count,
    input  logic [2:0]                   mode,
    input  logic [DATA_WIDTH-1:0]        dout,
    input  logic                         dout_valid,
    output logic                         dout_ack,
    output logic                         wr_en,
    input  logic                         wr_ready,
    output logic [ADR_W-1:0]             wr_adr,
    output logic [DATA_WIDTH*PACK_N-1:0] wr_data,
    output logic [PACK_N-1:0]            wr_be,
    output logic [DATA_WIDTH-1:0]        res_data,
    output logic                         res_valid,
    output logic                         busy,
`ifdef SIG_RESULT_WRITER_STALL_CNT_EN
    output logic [15:0]                  stall_cnt,
`endif
    output logic                         done
);

    import ann_sig_pkg::*;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_ack;
    logic                  r_res_valid;
    logic                  r_zero_done;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic [ADR_W-1:0]      r_adr;
    logic [CNT_W-1:0]      r_remaining;
    logic [2:0]            r_mode;

    logic                  w_start_idle;
    logic                  w_start_go;
    logic                  w_capture;
    logic                  w_accept;
    logic                  w_full;
    logic                  w_wr_en;
    logic                  w_busy;

    // A start only counts in IDLE; a zero count never leaves IDLE
    assign w_start_idle = (r_state == c_st_idle) && start;
    assign w_start_go   = w_start_idle && (count != '0);

    // The ack cycle never samples dout_valid, so the producer can advance
    assign w_capture = (r_state == c_st_collect) && dout_valid && !r_ack;
    assign w_accept  = (r_state == c_st_write) && wr_ready;

    sig_lane_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .PACK_N     (PACK_N)
    ) u_packer (
        .clk       (CLK),
        .rst       (RST),
        .i_capture (w_capture),
        .i_clear   (w_accept),
        .i_din     (dout),
        .o_data    (wr_data),
        .o_be      (wr_be),
        .o_full    (w_full)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs; the word goes out in the cycle
    // after its last ack so the ack/capture pair is fully retired first
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            c_st_idle: begin
                w_busy = 1'b0;
                if (w_start_go) begin
                    w_state_nxt = c_st_collect;
                end
            end
            c_st_collect: begin
                if (r_ack && (w_full || (r_remaining == '0))) begin
                    w_state_nxt = c_st_write;
                end
            end
            c_st_write: begin
                w_wr_en = 1'b1;
                if (wr_ready) begin
                    w_state_nxt = (r_remaining != '0) ? c_st_collect : c_st_done;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Layer parameters, address/remaining counters and handshake pulses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ack       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_zero_done <= 1'b0;
            r_adr       <= '0;
            r_remaining <= '0;
            r_mode      <= IM_DSTSEL_SIG1;
        end else begin
            r_ack       <= w_capture;
            r_res_valid <= w_capture && (r_mode == IM_DSTSEL_SIG2);
            r_zero_done <= w_start_idle && (count == '0);
            if (w_capture && (r_mode == IM_DSTSEL_SIG2)) begin
                r_res_data <= dout;
            end
            if (w_start_go) begin
                r_adr       <= base_adr;
                r_remaining <= count;
                // Anything other than the output-layer code behaves as hidden
                r_mode      <= (mode == IM_DSTSEL_SIG2) ? IM_DSTSEL_SIG2 : IM_DSTSEL_SIG1;
            end else begin
                if (w_capture) begin
                    r_remaining <= r_remaining - CNT_W'(1);
                end
                if (w_accept) begin
                    r_adr <= r_adr + ADR_W'(1);
                end
            end
        end
    end

`ifdef SIG_RESULT_WRITER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles a pending write is held off by the RAM
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_start_idle) begin
            r_stall_cnt <= '0;
        end else if (w_wr_en && !wr_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign dout_ack  = r_ack;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign wr_en     = w_wr_en;
    assign wr_adr    = r_adr;
    assign busy      = w_busy;
    assign done      = (r_state == c_st_done) || r_zero_done;

endmodule : sig_result_writer
`default_nettype wire

// File: tb/tb_sig_result_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sig_result_writer
//  Description : Self-checking bench for sig_result_writer (PACK_N = 4).
//                Table of layer runs with a write/result scoreboard, plus
//                hand sequences for zero count and mid-layer reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sig_result_writer;

    import ann_sig_pkg::*;

    logic        clk;
    logic        RST;
    logic        start;
    logic [9:0]  base_adr;
    logic [11:0] count;
    logic [2:0]  mode;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ack;
    logic        wr_en;
    logic        wr_ready;
    logic [9:0]  wr_adr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [7:0]  res_data;
    logic        res_valid;
    logic        busy;
    logic        done;
`ifdef SIG_RESULT_WRITER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks;
    int n_fail;

    typedef struct {
        logic [9:0]  base;
        logic [11:0] cnt;
        logic [2:0]  mode;
        logic [7:0]  seed;
        int          stall;
        bit          poke;
        int          exp_writes;
        int          exp_res;
        logic [9:0]  exp_last_adr;
        logic [31:0] exp_last_data;
        logic [3:0]  exp_last_be;
        logic [15:0] exp_stall;
    } vec_t;

    typedef struct {
        logic [9:0]  adr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    vec_t       vecs [6];
    wr_t        exp_wr_q [$];
    logic [7:0] exp_res_q [$];

    sig_result_writer #(
        .DATA_WIDTH (8),
        .PACK_N     (4),
        .ADR_W      (10),
        .CNT_W      (12)
    ) dut (
        .CLK        (clk),
        .RST        (RST),
        .start      (start),
        .base_adr   (base_adr),
        .count      (count),
        .mode       (mode),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ack   (dout_ack),
        .wr_en      (wr_en),
        .wr_ready   (wr_ready),
        .wr_adr     (wr_adr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .busy       (busy),
`ifdef SIG_RESULT_WRITER_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout_ack"},  64'(dout_ack),  64'd0);
        check({tag, "_wr_en"},     64'(wr_en),     64'd0);
        check({tag, "_wr_adr"},    64'(wr_adr),    64'd0);
        check({tag, "_wr_data"},   64'(wr_data),   64'd0);
        check({tag, "_wr_be"},     64'(wr_be),     64'd0);
        check({tag, "_res_data"},  64'(res_data),  64'd0);
        check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
    endtask

    // One full layer: build expectations, start, drive producer and RAM, score
    task automatic run_layer(input vec_t v, input string tag);
        logic [7:0]  data [$];
        logic [9:0]  adr;
        wr_t         e;
        wr_t         got;
        int          idx, acks, writes, res_n, dones, stall_left, done_cyc;
        bit          sig2, prev_ack, prev_wr_en, prev_accept, prev_last_lane, prev_last_write;
        logic [9:0]  prev_adr, last_adr;
        logic [31:0] prev_data, last_data;
        logic [3:0]  prev_be, last_be;

        sig2 = (v.mode == IM_DSTSEL_SIG2);
        exp_wr_q.delete();
        exp_res_q.delete();
        for (int i = 0; i < int'(v.cnt); i++) data.push_back(v.seed + 8'(i));
        adr = v.base;
        for (int w = 0; w * 4 < int'(v.cnt); w++) begin
            e.adr  = adr;
            e.data = '0;
            e.be   = '0;
            for (int k = 0; k < 4; k++) begin
                if (w * 4 + k < int'(v.cnt)) begin
                    e.data[k*8 +: 8] = data[w * 4 + k];
                    e.be[k]          = 1'b1;
                end
            end
            exp_wr_q.push_back(e);
            adr = adr + 10'd1;
        end
        if (sig2) foreach (data[i]) exp_res_q.push_back(data[i]);

        idx = 0; acks = 0; writes = 0; res_n = 0; dones = 0; done_cyc = -1;
        stall_left = v.stall;
        prev_ack = 0; prev_wr_en = 0; prev_accept = 0; prev_last_lane = 0; prev_last_write = 0;
        prev_adr = '0; prev_data = '0; prev_be = '0;
        last_adr = '0; last_data = '0; last_be = '0;

        @(posedge clk); #1;
        start      = 1'b1;
        base_adr   = v.base;
        count      = v.cnt;
        mode       = v.mode;
        dout_valid = 1'b1;
        dout       = data[0];
        wr_ready   = 1'b1;

        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (cyc == 1) check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
            if (prev_wr_en && !prev_accept) begin
                check({tag, "_hold_wr_en"},  64'(wr_en),   64'd1);
                check({tag, "_hold_adr"},    64'(wr_adr),  64'(prev_adr));
                check({tag, "_hold_data"},   64'(wr_data), 64'(prev_data));
                check({tag, "_hold_be"},     64'(wr_be),   64'(prev_be));
            end
            if (prev_last_lane)  check({tag, "_wr_latency"},   64'(wr_en), 64'd1);
            if (prev_last_write) check({tag, "_done_latency"}, 64'(done),  64'd1);
            if (dout_ack) begin
                check({tag, "_ack_in_write"}, 64'(wr_en),    64'd0);
                check({tag, "_ack_spacing"},  64'(prev_ack), 64'd0);
                acks++;
                idx++;
                if (sig2) begin
                    check({tag, "_res_valid"}, 64'(res_valid), 64'd1);
                    if (exp_res_q.size() > 0) check({tag, "_res_data"}, 64'(res_data), 64'(exp_res_q.pop_front()));
                    else check({tag, "_res_extra"}, 64'd1, 64'd0);
                    res_n++;
                end else begin
                    check({tag, "_res_valid_sig1"}, 64'(res_valid), 64'd0);
                end
            end else if (res_valid) begin
                check({tag, "_res_valid_no_ack"}, 64'(res_valid), 64'd0);
            end
            prev_accept = wr_en && wr_ready;
            prev_last_write = 0;
            if (prev_accept) begin
                writes++;
                got.adr = wr_adr; got.data = wr_data; got.be = wr_be;
                if (exp_wr_q.size() > 0) begin
                    e = exp_wr_q.pop_front();
                    check({tag, "_wr_adr"},  64'(got.adr),  64'(e.adr));
                    check({tag, "_wr_data"}, 64'(got.data), 64'(e.data));
                    check({tag, "_wr_be"},   64'(got.be),   64'(e.be));
                end else begin
                    check({tag, "_wr_extra"}, 64'd1, 64'd0);
                end
                last_adr = got.adr; last_data = got.data; last_be = got.be;
                prev_last_write = (writes == v.exp_writes);
            end
            prev_last_lane = dout_ack && (((acks % 4) == 0) || (acks == int'(v.cnt)));
            prev_wr_en = wr_en;
            prev_adr   = wr_adr;
            prev_data  = wr_data;
            prev_be    = wr_be;
            prev_ack   = dout_ack;
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check({tag, "_busy_after_done"}, 64'(busy), 64'd0);
                check({tag, "_done_one_cycle"},  64'(done), 64'd0);
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;

            @(posedge clk); #1;
            start = (v.poke && cyc == 3);
            if (start) begin
                base_adr = 10'h2AA;
                count    = 12'd1;
                mode     = IM_DSTSEL_SIG2;
            end
            dout_valid = (idx < int'(v.cnt));
            dout       = (idx < int'(v.cnt)) ? data[idx] : 8'h00;
            if (wr_en && stall_left > 0) begin
                wr_ready = 1'b0;
                stall_left--;
            end else begin
                wr_ready = 1'b1;
            end
        end

        @(posedge clk); #1;
        start      = 1'b0;
        dout_valid = 1'b0;
        wr_ready   = 1'b1;

        check({tag, "_done_count"},  64'(dones),            64'd1);
        check({tag, "_writes"},      64'(writes),           64'(v.exp_writes));
        check({tag, "_res_count"},   64'(res_n),            64'(v.exp_res));
        check({tag, "_wr_q_left"},   64'(exp_wr_q.size()),  64'd0);
        check({tag, "_res_q_left"},  64'(exp_res_q.size()), 64'd0);
        check({tag, "_last_adr"},    64'(last_adr),         64'(v.exp_last_adr));
        check({tag, "_last_data"},   64'(last_data),        64'(v.exp_last_data));
        check({tag, "_last_be"},     64'(last_be),          64'(v.exp_last_be));
`ifdef SIG_RESULT_WRITER_STALL_CNT_EN
        check({tag, "_stall_cnt"},   64'(stall_cnt),        64'(v.exp_stall));
`endif
    endtask

    // Start with count 0: done the next cycle, nothing else moves
    task automatic zero_count_seq();
        @(posedge clk); #1;
        start      = 1'b1;
        count      = 12'd0;
        base_adr   = 10'h123;
        mode       = IM_DSTSEL_SIG1;
        dout_valid = 1'b1;
        dout       = 8'h5A;
        @(negedge clk);
        check("zero_done_early", 64'(done), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zero_done_pulse", 64'(done),     64'd1);
        check("zero_busy",       64'(busy),     64'd0);
        check("zero_wr_en",      64'(wr_en),    64'd0);
        check("zero_ack",        64'(dout_ack), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("zero_done_clear", 64'(done),     64'd0);
        check("zero_wr_en2",     64'(wr_en),    64'd0);
        check("zero_ack2",       64'(dout_ack), 64'd0);
        @(posedge clk); #1;
        dout_valid = 1'b0;
    endtask

    // Asynchronous reset right after the third ack of a SIG2 layer
    task automatic reset_mid_layer_seq();
        int  acks;
        bit  adv;
        acks = 0;
        @(posedge clk); #1;
        start      = 1'b1;
        base_adr   = 10'h055;
        count      = 12'd8;
        mode       = IM_DSTSEL_SIG2;
        dout_valid = 1'b1;
        dout       = 8'h91;
        wr_ready   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 100 && acks < 3; c++) begin
            @(negedge clk);
            adv = dout_ack;
            if (dout_ack) acks++;
            if (acks < 3) begin
                @(posedge clk); #1;
                if (adv) dout = dout + 8'd1;
            end
        end
        check("rst_third_ack_seen", 64'(acks), 64'd3);
        RST = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk); #1;
        RST        = 1'b0;
        dout_valid = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        RST        = 1'b1;
        start      = 1'b0;
        base_adr   = '0;
        count      = '0;
        mode       = '0;
        dout       = '0;
        dout_valid = 1'b0;
        wr_ready   = 1'b1;

        //           base    cnt    mode            seed   stall poke wr res last_adr last_data     be     stall
        vecs[0] = '{10'h010, 12'd8, IM_DSTSEL_SIG1, 8'h01, 0, 1'b0, 2, 0, 10'h011, 32'h08070605, 4'hF, 16'd0};
        vecs[1] = '{10'h010, 12'd6, IM_DSTSEL_SIG2, 8'h11, 0, 1'b1, 2, 6, 10'h011, 32'h00001615, 4'h3, 16'd0};
        vecs[2] = '{10'h020, 12'd4, IM_DSTSEL_SIG1, 8'hA0, 5, 1'b0, 1, 0, 10'h020, 32'hA3A2A1A0, 4'hF, 16'd5};
        vecs[3] = '{10'h3FF, 12'd8, IM_DSTSEL_SIG2, 8'h40, 0, 1'b0, 2, 8, 10'h000, 32'h47464544, 4'hF, 16'd0};
        vecs[4] = '{10'h100, 12'd1, 3'd7,           8'hEE, 0, 1'b0, 1, 0, 10'h100, 32'h000000EE, 4'h1, 16'd0};
        vecs[5] = '{10'h005, 12'd9, IM_DSTSEL_SIG2, 8'h30, 0, 1'b0, 3, 9, 10'h007, 32'h00000038, 4'h1, 16'd0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
`ifdef SIG_RESULT_WRITER_STALL_CNT_EN
        check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        @(posedge clk); #1;
        RST = 1'b0;

        zero_count_seq();
        for (int i = 0; i < 6; i++) run_layer(vecs[i], $sformatf("v%0d", i));
        reset_mid_layer_seq();
        run_layer(vecs[1], "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_sig_result_writer
`default_nettype wire
